// File: rtl/booth_mul_arbiter.sv
// Round-robin front end that shares one 16x16 signed Booth multiplier core among NREQ clients.
// Grant->start 1 cycle, done->rsp_valid 2 cycles; one op in flight, holds in RESP while rsp_ready is low.
module booth_mul_arbiter #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = 1000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [16*NREQ-1:0]  req_m,
  input  logic [16*NREQ-1:0]  req_q,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [IDW-1:0]      rsp_id,
  output logic [31:0]         rsp_product,
  output logic                rsp_err,
  output logic                mul_start,
  output logic [15:0]         mul_m,
  output logic [15:0]         mul_q,
  input  logic                mul_done,
  input  logic [31:0]         mul_product,
  output logic                busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [IDW-1:0]  id_q, id_d;
  logic [15:0]     m_q, m_d;
  logic [15:0]     q_q, q_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            start_q, start_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [31:0]     prod_q, prod_d;
  logic            err_q, err_d;

  logic [15:0]     m_arr [NREQ];
  logic [15:0]     q_arr [NREQ];
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win_id;
  logic            found;
  logic [IDW:0]    cand;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_slice
    assign m_arr[gi] = req_m[16*gi +: 16];
    assign q_arr[gi] = req_q[16*gi +: 16];
  end

  // Search last+1, last+2, ... so the previous winner ends up with lowest priority.
  always_comb begin
    grant  = '0;
    win_id = '0;
    found  = 1'b0;
    cand   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_q} + (IDW+1)'(k);
      if (cand >= (IDW+1)'(NREQ)) begin
        cand = cand - (IDW+1)'(NREQ);
      end
      if (!found && req_valid[cand[IDW-1:0]]) begin
        found  = 1'b1;
        win_id = cand[IDW-1:0];
      end
    end
    if (found) begin
      grant[win_id] = 1'b1;
    end
  end

  assign req_ready = (rst_n && (state_q == S_IDLE)) ? grant : '0;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    m_d         = m_q;
    q_d         = q_q;
    cnt_d       = cnt_q;
    start_d     = 1'b0;
    rsp_valid_d = rsp_valid_q;
    prod_d      = prod_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          m_d     = m_arr[win_id];
          q_d     = q_arr[win_id];
          id_d    = win_id;
          last_d  = win_id;
          start_d = 1'b1;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (mul_done) begin
          state_d = S_CAPTURE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d       = 1'b1;
          prod_d      = '0;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_CAPTURE: begin
        prod_d      = mul_product;
        err_d       = 1'b0;
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      last_q      <= IDW'(NREQ - 1);
      id_q        <= '0;
      m_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      prod_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      m_q         <= m_d;
      q_q         <= q_d;
      cnt_q       <= cnt_d;
      start_q     <= start_d;
      rsp_valid_q <= rsp_valid_d;
      prod_q      <= prod_d;
      err_q       <= err_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = id_q;
  assign rsp_product = prod_q;
  assign rsp_err     = err_q;
  assign mul_start   = start_q;
  assign mul_m       = m_q;
  assign mul_q       = q_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Directed bench: a behavioural multiplier core feeds the default DUT; a TIMEOUT=16 copy sees a dead core.
module tb_booth_mul_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid, req_ready;
  logic [63:0] req_m, req_q;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_product;
  logic        mul_start, mul_done, busy;
  logic [15:0] mul_m, mul_q;
  logic [31:0] mul_product;

  logic [3:0]  t_req_valid, t_req_ready;
  logic [63:0] t_req_m, t_req_q;
  logic        t_rsp_valid, t_rsp_ready, t_rsp_err;
  logic [1:0]  t_rsp_id;
  logic [31:0] t_rsp_product;
  logic        t_mul_start, t_mul_done, t_busy;
  logic [15:0] t_mul_m, t_mul_q;
  logic [31:0] t_mul_product;

  int checks = 0;
  int errors = 0;

  int   core_cnt;
  logic core_busy;

  always #5 clk = ~clk;

  booth_mul_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_m(req_m), .req_q(req_q),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_m(mul_m), .mul_q(mul_q),
    .mul_done(mul_done), .mul_product(mul_product), .busy(busy)
  );

  booth_mul_arbiter #(.NREQ(4), .IDW(2), .TIMEOUT(16)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .req_valid(t_req_valid), .req_ready(t_req_ready), .req_m(t_req_m), .req_q(t_req_q),
    .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_id(t_rsp_id),
    .rsp_product(t_rsp_product), .rsp_err(t_rsp_err),
    .mul_start(t_mul_start), .mul_m(t_mul_m), .mul_q(t_mul_q),
    .mul_done(t_mul_done), .mul_product(t_mul_product), .busy(t_busy)
  );

  // Core stand-in: done 4 cycles after start, product valid the cycle after done, junk otherwise.
  always @(posedge clk) begin
    if (!rst_n) begin
      core_busy   <= 1'b0;
      core_cnt    <= 0;
      mul_done    <= 1'b0;
      mul_product <= 32'hDEADBEEF;
    end else begin
      mul_done <= 1'b0;
      if (mul_done) begin
        mul_product <= $signed({{16{mul_m[15]}}, mul_m}) * $signed({{16{mul_q[15]}}, mul_q});
      end
      if (mul_start) begin
        core_busy   <= 1'b1;
        core_cnt    <= 3;
        mul_product <= 32'hDEADBEEF;
      end else if (core_busy) begin
        if (core_cnt == 0) begin
          core_busy <= 1'b0;
          mul_done  <= 1'b1;
        end else begin
          core_cnt <= core_cnt - 1;
        end
      end
    end
  end

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rsp_valid, rsp_id, rsp_product, rsp_err, mul_start, mul_m, mul_q, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b id=%0d p=%h e=%0b st=%0b m=%h q=%h busy=%0b, expected all 0",
               rsp_valid, rsp_id, rsp_product, rsp_err, mul_start, mul_m, mul_q, busy);
    end
    req_valid = 4'b0001;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_req_ready: got %b, expected 0000", req_ready);
    end
    checks++;
    if (t_busy !== 1'b0 || t_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_timeout_inst: got busy=%0b v=%0b, expected 0 0", t_busy, t_rsp_valid);
    end
    req_valid = 4'b0000;
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    bit seen;
    @(negedge clk);
    req_m[15:0] = 16'd3;
    req_q[15:0] = 16'd2;
    req_valid   = 4'b0001;
    rsp_ready   = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: got %b, expected 0001", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    checks++;
    if (mul_start !== 1'b1 || req_ready !== 4'b0000 || mul_m !== 16'd3 || mul_q !== 16'd2) begin
      errors++;
      $display("FAIL single_start: got st=%0b rdy=%b m=%h q=%h, expected 1 0000 0003 0002",
               mul_start, req_ready, mul_m, mul_q);
    end
    @(negedge clk);
    checks++;
    if (mul_start !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL single_start_pulse: got st=%0b busy=%0b, expected 0 1", mul_start, busy);
    end
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (mul_done === 1'b1) seen = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL single_done_wait: got no mul_done, expected one within 50 cycles");
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early_rsp: got rsp_valid=%0b at D+1, expected 0", rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_product !== 32'd6 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_resp: got v=%0b id=%0d p=%h e=%0b, expected 1 0 00000006 0",
               rsp_valid, rsp_id, rsp_product, rsp_err);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_release: got v=%0b busy=%0b, expected 0 0", rsp_valid, busy);
    end
  endtask

  task automatic test_signed();
    logic [15:0] vm [3];
    logic [15:0] vq [3];
    logic [31:0] vp [3];
    bit ok, stable;
    vm = '{16'hFFFC, 16'hFFFA, 16'h0008};
    vq = '{16'h0005, 16'hFFFE, 16'h0000};
    vp = '{32'hFFFFFFEC, 32'h0000000C, 32'h00000000};
    for (int n = 0; n < 3; n++) begin
      req_m[47:32] = vm[n];
      req_q[47:32] = vq[n];
      req_valid    = 4'b0100;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin
        errors++;
        $display("FAIL signed_grant[%0d]: got %b, expected 0100", n, req_ready);
      end
      @(negedge clk);
      req_valid = 4'b0000;
      stable = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
        @(negedge clk);
        if (mul_m !== vm[n] || mul_q !== vq[n]) stable = 1'b0;
        if (rsp_valid === 1'b1) ok = 1'b1;
      end
      checks++;
      if (!stable || !ok) begin
        errors++;
        $display("FAIL signed_hold[%0d]: got stable=%0b rsp_seen=%0b, expected 1 1", n, stable, ok);
      end
      checks++;
      if (rsp_id !== 2'd2 || rsp_product !== vp[n] || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL signed_product[%0d]: got id=%0d p=%h e=%0b, expected 2 %h 0",
                 n, rsp_id, rsp_product, rsp_err, vp[n]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    int          order [5];
    logic [31:0] vp [4];
    bit ok;
    order = '{0, 1, 2, 3, 0};
    vp    = '{32'h00000007, 32'hFFFFFFF4, 32'h00002710, 32'hFFFF0000};
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req_m = {16'h8000, 16'd100, 16'hFFFD, 16'd1};
    req_q = {16'd2,    16'd100, 16'd4,    16'd7};
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      checks++;
      if (req_ready !== (4'b0001 << order[n])) begin
        errors++;
        $display("FAIL rr_grant[%0d]: got %b, expected requester %0d", n, req_ready, order[n]);
      end
      wait_rsp(ok);
      checks++;
      if (!ok || rsp_id !== 2'(order[n]) || rsp_product !== vp[order[n]] || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL rr_resp[%0d]: got seen=%0b id=%0d p=%h e=%0b, expected 1 %0d %h 0",
                 n, ok, rsp_id, rsp_product, rsp_err, order[n], vp[order[n]]);
      end
      @(negedge clk);
    end
    req_valid = 4'b0000;
  endtask

  task automatic test_backpressure();
    bit ok;
    req_m[63:48] = 16'hFFF9;
    req_q[63:48] = 16'd9;
    req_valid    = 4'b1000;
    rsp_ready    = 1'b0;
    #1;
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_grant: got %b, expected 1000", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0010;
    wait_rsp(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_rsp_wait: got no rsp_valid, expected one within 100 cycles");
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || rsp_product !== 32'hFFFFFFC1 || req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%0b id=%0d p=%h rdy=%b, expected 1 3 ffffffc1 0000",
                 i, rsp_valid, rsp_id, rsp_product, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL bp_next_grant: got v=%0b rdy=%b, expected 0 0010", rsp_valid, req_ready);
    end
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_id !== 2'd1 || rsp_product !== 32'hFFFFFFF4) begin
      errors++;
      $display("FAIL bp_second_op: got seen=%0b id=%0d p=%h, expected 1 1 fffffff4", ok, rsp_id, rsp_product);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    bit bad;
    t_req_m[15:0] = 16'd5;
    t_req_q[15:0] = 16'd5;
    t_req_valid   = 4'b0001;
    t_rsp_ready   = 1'b0;
    #1;
    checks++;
    if (t_req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL to_grant: got %b, expected 0001", t_req_ready);
    end
    @(negedge clk);
    t_req_valid = 4'b0000;
    checks++;
    if (t_mul_start !== 1'b1) begin
      errors++;
      $display("FAIL to_start: got %0b, expected 1", t_mul_start);
    end
    bad = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (t_rsp_valid !== 1'b0 || t_busy !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL to_wait_len: got early rsp or idle within 16 WAIT cycles, expected none");
    end
    @(negedge clk);
    checks++;
    if (t_rsp_valid !== 1'b1 || t_rsp_err !== 1'b1 || t_rsp_product !== 32'd0 || t_rsp_id !== 2'd0) begin
      errors++;
      $display("FAIL to_resp: got v=%0b e=%0b p=%h id=%0d, expected 1 1 00000000 0",
               t_rsp_valid, t_rsp_err, t_rsp_product, t_rsp_id);
    end
    t_rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (t_busy !== 1'b0 || t_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_release: got busy=%0b v=%0b, expected 0 0", t_busy, t_rsp_valid);
    end
    t_mul_done = 1'b1;
    @(negedge clk);
    t_mul_done = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (t_rsp_valid !== 1'b0 || t_busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL to_late_done: got response or busy after late mul_done, expected none");
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    req_m[47:32] = 16'd9;
    req_q[47:32] = 16'd9;
    req_valid    = 4'b0100;
    rsp_ready    = 1'b1;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL rm_grant: got %b, expected 0100", req_ready);
    end
    @(negedge clk);
    req_valid = 4'b0000;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mul_start !== 1'b0) begin
      errors++;
      $display("FAIL rm_in_wait: got busy=%0b st=%0b, expected 1 0", busy, mul_start);
    end
    rst_n     = 1'b0;
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0000) begin
      errors++;
      $display("FAIL rm_ready_in_reset: got %b, expected 0000", req_ready);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rsp_valid !== 1'b0 || mul_start !== 1'b0 || mul_m !== 16'd0) begin
      errors++;
      $display("FAIL rm_after_reset: got busy=%0b v=%0b st=%0b m=%h, expected 0 0 0 0000",
               busy, rsp_valid, mul_start, mul_m);
    end
    rst_n = 1'b1;
    req_m[31:16] = 16'd11;
    req_q[31:16] = 16'hFFF5;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL rm_last_reset: got %b, expected 0010", req_ready);
    end
    req_valid = 4'b0010;
    @(negedge clk);
    req_valid = 4'b0000;
    checks++;
    if (mul_start !== 1'b1 || mul_m !== 16'd11 || mul_q !== 16'hFFF5) begin
      errors++;
      $display("FAIL rm_restart: got st=%0b m=%h q=%h, expected 1 000b fff5", mul_start, mul_m, mul_q);
    end
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_id !== 2'd1 || rsp_product !== 32'hFFFFFF87 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL rm_resp: got seen=%0b id=%0d p=%h e=%0b, expected 1 1 ffffff87 0",
               ok, rsp_id, rsp_product, rsp_err);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    req_valid     = '0;
    req_m         = '0;
    req_q         = '0;
    rsp_ready     = 1'b0;
    t_req_valid   = '0;
    t_req_m       = '0;
    t_req_q       = '0;
    t_rsp_ready   = 1'b0;
    t_mul_done    = 1'b0;
    t_mul_product = 32'h12345678;
    test_reset();
    test_single();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
